circle_raster: RTL and testbench

CIRCLE_RASTER -- requirements
Module: circle_raster

---
 rtl/circle_pkg.sv | 15 +
 rtl/circle_octant_map.sv | 51 +++++
 rtl/circle_raster.sv | 124 ++++++++++++
 tb/tb_circle_raster.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// Shared types and constants for the midpoint circle rasteriser.
// Coordinates widen by SIGN_EXT bits so +/- offsets and the decision term fit signed.
package circle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        STEP,
        DONE
    } state_t;

    localparam int IDX_W    = 3;
    localparam int SIGN_EXT = 2;

endpackage

// File: rtl/circle_octant_map.sv
// Maps one midpoint step (x,y) and candidate index onto a screen point or a clamped span.
// Pure combinational; visible is low when the candidate falls entirely off-screen.
module circle_octant_map
    import circle_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0]          cx,
    input  logic [CW-1:0]          cy,
    input  logic signed [CW+SIGN_EXT-1:0] x,
    input  logic signed [CW+SIGN_EXT-1:0] y,
    input  logic [IDX_W-1:0]       idx,
    input  logic                   fill,
    output logic [CW-1:0]          px,
    output logic [CW-1:0]          py,
    output logic [CW-1:0]          pe,
    output logic                   visible
);

    localparam int SW = CW + SIGN_EXT;
    localparam logic signed [SW-1:0] MAX_C = SW'(2**CW - 1);

    logic signed [SW-1:0] scx, scy, h, v, row, lo, hi, lo_c, hi_c;
    logic                 h_swap, row_neg;

    // Outline: idx[2] swaps axes, idx[1] negates row, idx[0] negates column.
    // Fill: idx[1] swaps axes, idx[0] negates row, span covers both columns.
    always_comb begin
        scx     = $signed({{SIGN_EXT{1'b0}}, cx});
        scy     = $signed({{SIGN_EXT{1'b0}}, cy});
        h_swap  = fill ? idx[1] : idx[2];
        row_neg = fill ? idx[0] : idx[1];
        h       = h_swap ? y : x;
        v       = h_swap ? x : y;
        row     = row_neg ? (scy - v) : (scy + v);
        if (fill) begin
            lo = scx - h;
            hi = scx + h;
        end else begin
            lo = idx[0] ? (scx - h) : (scx + h);
            hi = lo;
        end
        lo_c    = (lo < 0) ? '0 : lo;
        hi_c    = (hi > MAX_C) ? MAX_C : hi;
        visible = (row >= 0) && (row <= MAX_C) && (hi >= 0) && (lo <= MAX_C);
        px      = CW'(lo_c);
        pe      = CW'(hi_c);
        py      = CW'(row);
    end

endmodule

// File: rtl/circle_raster.sv
// Midpoint circle rasteriser: walks one octant and streams 8 points or 4 spans per step
// over a VALID/READY handshake, skipping candidates that land off-screen.
module circle_raster
    import circle_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          START,
    input  logic [CW-1:0] X_0,
    input  logic [CW-1:0] Y_0,
    input  logic [CW-1:0] R,
    input  logic          FILL,
    output logic [CW-1:0] X_Out,
    output logic [CW-1:0] Y_Out,
    output logic [CW-1:0] X_End,
    output logic          VALID,
    input  logic          READY,
    output logic          BUSY,
    output logic          FINISH
);

    localparam int SW = CW + SIGN_EXT;

    state_t               state, state_nxt;
    logic signed [SW-1:0] x, y, d;
    logic signed [SW-1:0] x_nxt, y_nxt, d_nxt;
    logic [IDX_W-1:0]     idx;
    logic [CW-1:0]        cx, cy;
    logic                 fill;
    logic [CW-1:0]        map_x, map_y, map_e;
    logic                 map_vis;
    logic                 last_idx, advance;

    circle_octant_map #(.CW(CW)) u_map (
        .cx      (cx),
        .cy      (cy),
        .x       (x),
        .y       (y),
        .idx     (idx),
        .fill    (fill),
        .px      (map_x),
        .py      (map_y),
        .pe      (map_e),
        .visible (map_vis)
    );

    // Dropped candidates advance immediately so off-screen points cost one cycle each.
    assign last_idx = (idx == (fill ? IDX_W'(3) : IDX_W'(7)));
    assign advance  = (state == EMIT) && (!map_vis || READY);

    always_comb begin
        x_nxt = x + SW'(1);
        y_nxt = y;
        d_nxt = d + (x <<< 1) + SW'(3);
        if (d >= 0) begin
            y_nxt = y - SW'(1);
            d_nxt = d + ((x - y) <<< 1) + SW'(5);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        VALID     = 1'b0;
        BUSY      = (state != IDLE);
        FINISH    = (state == DONE);
        X_Out     = '0;
        Y_Out     = '0;
        X_End     = '0;
        case (state)
            IDLE: if (START) state_nxt = EMIT;
            EMIT: begin
                VALID = map_vis;
                if (map_vis) begin
                    X_Out = map_x;
                    Y_Out = map_y;
                    X_End = map_e;
                end
                if (advance && last_idx) state_nxt = STEP;
            end
            STEP: state_nxt = (x_nxt <= y_nxt) ? EMIT : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            x    <= '0;
            y    <= '0;
            d    <= '0;
            idx  <= '0;
            cx   <= '0;
            cy   <= '0;
            fill <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    cx   <= X_0;
                    cy   <= Y_0;
                    fill <= FILL;
                    x    <= '0;
                    y    <= $signed({{SIGN_EXT{1'b0}}, R});
                    d    <= SW'(1) - $signed({{SIGN_EXT{1'b0}}, R});
                    idx  <= '0;
                end
                EMIT: if (advance) idx <= last_idx ? '0 : idx + IDX_W'(1);
                STEP: begin
                    x <= x_nxt;
                    y <= y_nxt;
                    d <= d_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_circle_raster.sv
// Directed bench for circle_raster: vector table of whole circles plus hand-written
// sequences for stalls, ignored START, reset mid-circle and exact beat lists.
module tb_circle_raster;

    localparam int CW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          START = 1'b0;
    logic [CW-1:0] X_0 = '0, Y_0 = '0, R = '0;
    logic          FILL = 1'b0;
    logic          READY = 1'b1;
    logic [CW-1:0] X_Out, Y_Out, X_End;
    logic          VALID, BUSY, FINISH;

    always #5 ACLK = ~ACLK;

    circle_raster #(.CW(CW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .START   (START),
        .X_0     (X_0),
        .Y_0     (Y_0),
        .R       (R),
        .FILL    (FILL),
        .X_Out   (X_Out),
        .Y_Out   (Y_Out),
        .X_End   (X_End),
        .VALID   (VALID),
        .READY   (READY),
        .BUSY    (BUSY),
        .FINISH  (FINISH)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] e;
    } beat_t;

    typedef struct {
        string      name;
        logic [7:0] x0, y0, r;
        logic       fill;
        int         beats;
        beat_t      first, last;
        int         lo, hi;
    } vec_t;

    beat_t got[$];
    beat_t exp_q[$];
    vec_t  vecs[5];
    int    vectors = 0, miscompares = 0;
    int    finishes, busy_err, stable_err, post_busy;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input string n, input int x0, y0, r, fl, nb,
                                   fx, fy, fe, lx, ly, le, lo, hi);
        vec_t v;
        v.name  = n;
        v.x0    = 8'(x0);
        v.y0    = 8'(y0);
        v.r     = 8'(r);
        v.fill  = fl[0];
        v.beats = nb;
        v.first = '{x: 8'(fx), y: 8'(fy), e: 8'(fe)};
        v.last  = '{x: 8'(lx), y: 8'(ly), e: 8'(le)};
        v.lo    = lo;
        v.hi    = hi;
        return v;
    endfunction

    task automatic expectBeat(input int bx, by, be);
        exp_q.push_back('{x: 8'(bx), y: 8'(by), e: 8'(be)});
    endtask

    // Eight octant reflections of one step, in emission order, clipped to the screen.
    task automatic expandOutline(input int cx, cy, a, b);
        int px, py;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: begin px = cx + a; py = cy + b; end
                1: begin px = cx - a; py = cy + b; end
                2: begin px = cx + a; py = cy - b; end
                3: begin px = cx - a; py = cy - b; end
                4: begin px = cx + b; py = cy + a; end
                5: begin px = cx - b; py = cy + a; end
                6: begin px = cx + b; py = cy - a; end
                default: begin px = cx - b; py = cy - a; end
            endcase
            if (px >= 0 && px <= 255 && py >= 0 && py <= 255) expectBeat(px, py, px);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] x0, y0, r, input logic fl,
                                 input bit rand_ready, input bit poke_start);
        int    cycles;
        bit    done, have_prev;
        beat_t prev;
        logic  prev_valid;
        got.delete();
        finishes = 0; busy_err = 0; stable_err = 0; post_busy = 0;
        cycles = 0; done = 0; have_prev = 0; prev = '0; prev_valid = 1'b0;
        @(negedge ACLK);
        X_0 = x0; Y_0 = y0; R = r; FILL = fl; START = 1'b1; READY = 1'b1;
        while (!done && cycles < 2000) begin
            @(negedge ACLK);
            cycles++;
            if (have_prev && ({prev_valid, prev} !== {VALID, X_Out, Y_Out, X_End})) stable_err++;
            if (!BUSY) busy_err++;
            if (FINISH) begin
                finishes++;
                done = 1;
            end
            START = (poke_start && (cycles == 3 || FINISH)) ? 1'b1 : 1'b0;
            if (poke_start && cycles == 3) begin
                X_0 = 8'd10; Y_0 = 8'd20; R = 8'd7;
            end
            READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (VALID && READY) got.push_back('{x: X_Out, y: Y_Out, e: X_End});
            have_prev  = VALID && !READY;
            prev_valid = VALID;
            prev       = '{x: X_Out, y: Y_Out, e: X_End};
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL run_timeout: got no FINISH in %0d cycles, expected FINISH", cycles);
        end
        repeat (4) begin
            @(negedge ACLK);
            START = 1'b0;
            if (FINISH) finishes++;
            if (BUSY || VALID) post_busy++;
        end
    endtask

    task automatic checkRun(input vec_t v);
        int oob;
        oob = 0;
        foreach (got[i]) begin
            if (got[i].x < v.lo || got[i].x > v.hi || got[i].y < v.lo || got[i].y > v.hi ||
                got[i].e < v.lo || got[i].e > v.hi) oob++;
        end
        checkOutput({v.name, "_beats"}, got.size(), v.beats);
        checkOutput({v.name, "_first"}, (got.size() > 0) ? int'(got[0]) : -1, int'(v.first));
        checkOutput({v.name, "_last"}, (got.size() > 0) ? int'(got[$]) : -1, int'(v.last));
        checkOutput({v.name, "_out_of_bounds"}, oob, 0);
        checkOutput({v.name, "_finish_pulses"}, finishes, 1);
        checkOutput({v.name, "_busy_drop"}, busy_err, 0);
        checkOutput({v.name, "_stall_unstable"}, stable_err, 0);
        checkOutput({v.name, "_idle_after"}, post_busy, 0);
    endtask

    task automatic compareSeq(input string name);
        checkOutput({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("%s_beat%0d", name, i), int'(got[i]), int'(exp_q[i]));
    endtask

    task automatic buildExpectedA();
        exp_q.delete();
        expandOutline(100, 100, 0, 5);
        expandOutline(100, 100, 1, 5);
        expandOutline(100, 100, 2, 5);
        expandOutline(100, 100, 3, 4);
    endtask

    initial begin
        vecs[0] = mkVec("outline_c100_r5",   100, 100, 5, 0, 32, 100, 105, 100,  96,  97,  96,  95, 105);
        vecs[1] = mkVec("outline_origin_r5",   0,   0, 5, 0, 10,   0,   5,   0,   4,   3,   4,   0,   5);
        vecs[2] = mkVec("fill_c100_r5",      100, 100, 5, 1, 16, 100, 105, 100,  96,  97, 104,  95, 105);
        vecs[3] = mkVec("outline_r0",         50,  60, 0, 0,  8,  50,  60,  50,  50,  60,  50,  50,  60);
        vecs[4] = mkVec("fill_corner_r3",    255, 255, 3, 1,  7, 255, 252, 255, 253, 253, 255, 252, 255);

        #12;
        checkOutput("reset_valid",  VALID,  0);
        checkOutput("reset_busy",   BUSY,   0);
        checkOutput("reset_finish", FINISH, 0);
        checkOutput("reset_xyz",    {X_Out, Y_Out, X_End}, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].x0, vecs[i].y0, vecs[i].r, vecs[i].fill, 1'b0, 1'b0);
            checkRun(vecs[i]);
        end

        $display("[TB] centre 100 r5 outline with random READY");
        applyStimulus(8'd100, 8'd100, 8'd5, 1'b0, 1'b1, 1'b0);
        checkRun(vecs[0]);
        buildExpectedA();
        compareSeq("outline_c100_stalled");

        $display("[TB] origin r5 exact clipped order");
        applyStimulus(8'd0, 8'd0, 8'd5, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        expectBeat(0, 5, 0); expectBeat(0, 5, 0); expectBeat(5, 0, 5); expectBeat(5, 0, 5);
        expectBeat(1, 5, 1); expectBeat(5, 1, 5); expectBeat(2, 5, 2); expectBeat(5, 2, 5);
        expectBeat(3, 4, 3); expectBeat(4, 3, 4);
        compareSeq("outline_origin_seq");

        $display("[TB] corner fill clamp order");
        applyStimulus(8'd255, 8'd255, 8'd3, 1'b1, 1'b1, 1'b0);
        exp_q.delete();
        expectBeat(255, 252, 255); expectBeat(252, 255, 255); expectBeat(252, 255, 255);
        expectBeat(254, 252, 255); expectBeat(252, 254, 255);
        expectBeat(253, 253, 255); expectBeat(253, 253, 255);
        compareSeq("fill_corner_seq");

        $display("[TB] START pulsed while busy and during DONE");
        applyStimulus(8'd50, 8'd60, 8'd0, 1'b0, 1'b0, 1'b1);
        checkRun(vecs[3]);

        $display("[TB] reset mid-circle then restart");
        @(negedge ACLK);
        X_0 = 8'd100; Y_0 = 8'd100; R = 8'd5; FILL = 1'b0; READY = 1'b1; START = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        repeat (3) @(negedge ACLK);
        checkOutput("pre_reset_valid", VALID, 1);
        #2 ARESETn = 1'b0;
        #1;
        checkOutput("async_reset_valid",  VALID,  0);
        checkOutput("async_reset_busy",   BUSY,   0);
        checkOutput("async_reset_finish", FINISH, 0);
        checkOutput("async_reset_xyz",    {X_Out, Y_Out, X_End}, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        applyStimulus(8'd100, 8'd100, 8'd5, 1'b0, 1'b0, 1'b0);
        checkRun(vecs[0]);
        buildExpectedA();
        compareSeq("after_reset_seq");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
